idex_stage: RTL and testbench

IDEX_STAGE -- requirements
Module: idex_stage

---
 rtl/idex_stage.sv | 142 ++++++++++++++
 tb/tb_idex_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register with valid/ready handshake on both sides.
//
// Optional feature: define IDEX_SKID_EN to add a one-entry skid buffer. In_ready
// then comes straight from a flop (skid empty), and out_ready has no
// combinational path to in_ready. The default build has no skid buffer, and
// in_ready = !out_valid || out_ready.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready decode-side handshake
//   in_*              instruction payload from decode
//   flush             discard every held instruction (branch redirect)
//   out_valid/out_ready execute-side handshake
//   out_*             registered payload; out_ctrl is forced to zero on a bubble
//   clr_stats         clear stall_cnt
//   stall_cnt         saturating count of cycles with out_valid && !out_ready
module idex_stage #(
  parameter int PC_WIDTH   = 9,
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5,
  parameter int CTRL_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [DATA_WIDTH-1:0] in_rd1,
  input  logic [DATA_WIDTH-1:0] in_rd2,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [REG_AW-1:0]     in_rs1,
  input  logic [REG_AW-1:0]     in_rs2,
  input  logic [REG_AW-1:0]     in_rd,
  input  logic [3:0]            in_funct,
  input  logic                  in_aui,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [DATA_WIDTH-1:0] out_rd1,
  output logic [DATA_WIDTH-1:0] out_rd2,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [REG_AW-1:0]     out_rs1,
  output logic [REG_AW-1:0]     out_rs2,
  output logic [REG_AW-1:0]     out_rd,
  output logic [3:0]            out_funct,
  output logic                  out_aui,
  input  logic                  clr_stats,
  output logic [15:0]           stall_cnt
);

  localparam int PW = CTRL_WIDTH + PC_WIDTH + 3*DATA_WIDTH + 3*REG_AW + 4 + 1;

  logic [PW-1:0]         w_in_pl;
  logic [PW-1:0]         r_out_pl;
  logic                  r_out_valid;
  logic                  w_out_free;
  logic                  w_accept;
  logic [CTRL_WIDTH-1:0] w_out_ctrl;
  logic [15:0]           r_stall_cnt;

  assign w_in_pl = {in_ctrl, in_pc, in_rd1, in_rd2, in_imm,
                    in_rs1, in_rs2, in_rd, in_funct, in_aui};

  // Output register can take a new entry when empty or being consumed now.
  assign w_out_free = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;

`ifdef IDEX_SKID_EN
  logic          r_skid_valid;
  logic [PW-1:0] r_skid_pl;

  // Registered ready: only the skid flop and the flush line feed it.
  assign in_ready = !r_skid_valid && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid  <= 1'b0;
      r_out_pl     <= '0;
      r_skid_valid <= 1'b0;
      r_skid_pl    <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      // Skid entry is older than anything on the input, so it goes first.
      // in_ready is low while the skid is full, so no accept collides here.
      if (r_skid_valid) begin
        r_out_pl     <= r_skid_pl;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_pl    <= w_in_pl;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      // Output stalled: park the new instruction in the skid.
      r_skid_pl    <= w_in_pl;
      r_skid_valid <= 1'b1;
    end
  end
`else
  assign in_ready = !flush && w_out_free;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_pl    <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_pl    <= w_in_pl;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (clr_stats) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign {w_out_ctrl, out_pc, out_rd1, out_rd2, out_imm,
          out_rs1, out_rs2, out_rd, out_funct, out_aui} = r_out_pl;

  // Bubbles must not carry live control bits into execute.
  assign out_ctrl  = r_out_valid ? w_out_ctrl : '0;
  assign out_valid = r_out_valid;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_idex_stage.sv
module tb_idex_stage;

  localparam int PW = 134;
`ifdef IDEX_SKID_EN
  localparam int SKID = 1;
`else
  localparam int SKID = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_ctrl, in_pc;
  logic [31:0] in_rd1, in_rd2, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [3:0]  in_funct;
  logic        in_aui;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [8:0]  out_ctrl, out_pc;
  logic [31:0] out_rd1, out_rd2, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_funct;
  logic        out_aui;
  logic        clr_stats = 1'b0;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  idex_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_pc(in_pc), .in_rd1(in_rd1), .in_rd2(in_rd2),
    .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_funct(in_funct), .in_aui(in_aui),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_pc(out_pc), .out_rd1(out_rd1), .out_rd2(out_rd2),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_funct(out_funct), .out_aui(out_aui),
    .clr_stats(clr_stats), .stall_cnt(stall_cnt)
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  logic [8:0] q_pc[$];
  int q_cyc[$];
  logic [8:0] next_pc = '0;
  bit lat_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Directed payload for a given pc; every field is a distinct hand-chosen function of pc.
  function automatic logic [PW-1:0] mk(input logic [8:0] p);
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  a, b, c;
    rd1 = 32'h1000_0000 | {23'd0, p};
    rd2 = ~(32'h0BAD_0000 + {23'd0, p});
    imm = {23'd0, p} * 32'd7;
    a = p[4:0];
    b = a + 5'd1;
    c = a ^ 5'h1F;
    return {9'h1A5 ^ p, p, rd1, rd2, imm, a, b, c, p[3:0] ^ 4'hA, p[0]};
  endfunction

  function automatic logic [PW-1:0] act();
    return {out_ctrl, out_pc, out_rd1, out_rd2, out_imm,
            out_rs1, out_rs2, out_rd, out_funct, out_aui};
  endfunction

  task automatic chk(input string name, input logic [159:0] a, input logic [159:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic drive(input logic [8:0] p);
    {in_ctrl, in_pc, in_rd1, in_rd2, in_imm, in_rs1, in_rs2, in_rd, in_funct, in_aui} = mk(p);
  endtask

  // Scoreboard monitor: pops on every output transfer, checks holds and bubbles.
  logic [PW-1:0] prev_pl;
  bit            prev_stall = 1'b0;
  logic [8:0]    mon_p;
  int            mon_c;
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold_stable", {out_valid, act()}, {1'b1, prev_pl});
      if (!out_valid) chk("bubble_ctrl", out_ctrl, 0);
      if (out_valid && out_ready) begin
        if (q_pc.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_out: got pc %0d expected no output", out_pc);
        end else begin
          mon_p = q_pc.pop_front();
          mon_c = q_cyc.pop_front();
          chk("payload", act(), mk(mon_p));
          if (lat_chk) chk("latency", cyc - mon_c, 1);
        end
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_pl    = act();
    end
  end

  // One clock: record an input transfer in the scoreboard, then advance.
  task automatic tick();
    @(negedge clk); #1;
    if (rst && in_valid && in_ready) begin
      q_pc.push_back(next_pc);
      q_cyc.push_back(cyc);
      next_pc++;
    end
    if (rst && flush) begin
      q_pc.delete();
      q_cyc.delete();
    end
    @(posedge clk); #1;
    drive(next_pc);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q_pc.size() != 0; i++) tick();
    checks++;
    if (q_pc.size() != 0) begin
      errs++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q_pc.size());
    end
    tick();
    chk("drain_empty", out_valid, 0);
  endtask

  logic [159:0] rnd;

  initial begin
    // Reset with random inputs.
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      {in_ctrl, in_pc, in_rd1, in_rd2, in_imm, in_rs1, in_rs2, in_rd, in_funct, in_aui} = rnd[PW-1:0];
      in_valid  = 1'b1;
      out_ready = rnd[150];
      clr_stats = rnd[151];
      #7;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_payload", act(), 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      #3;
    end
    clr_stats = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_in_ready", in_ready, 1);

    // Streaming: pc 0..7 back to back, one-cycle latency, no gaps.
    next_pc = 9'd0;
    drive(next_pc);
    in_valid = 1'b1;
    lat_chk  = 1'b1;
    repeat (8) tick();
    in_valid = 1'b0;
    chk("stream_accepts", next_pc, 8);
    drain();
    lat_chk = 1'b0;

    // Backpressure: 5 stalled cycles with input pending.
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    next_pc   = 9'd10;
    drive(next_pc);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    repeat (5) tick();
    chk("bp_stall_cnt", stall_cnt, 5);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_pc", {out_valid, out_pc}, {1'b1, 9'd10});
    chk("bp_accepted", next_pc, 11 + SKID);
    drain();

    // Flush while holding pc 3 (and 4 in the skid) with another pc offered.
    next_pc = 9'd3;
    drive(next_pc);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_ctrl", out_ctrl, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("flush_skid_empty", out_valid, 0);
    next_pc = 9'h20;
    drive(next_pc);
    in_valid = 1'b1;
    repeat (2) tick();
    drain();

    // Stall counter saturation and clear.
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    next_pc   = 9'h30;
    drive(next_pc);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (65534) tick();
    chk("sat_fffe", stall_cnt, 16'hFFFE);
    repeat (6) tick();
    chk("sat_ffff", stall_cnt, 16'hFFFF);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_priority", stall_cnt, 0);
    tick();
    chk("count_after_clr", stall_cnt, 1);
    drain();

    // Reset in the middle of a stall.
    next_pc = 9'h40;
    drive(next_pc);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_payload", act(), 0);
    chk("mid_rst_stall_cnt", stall_cnt, 0);
    q_pc.delete();
    q_cyc.delete();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", in_ready, 1);
    drive(next_pc);
    repeat (4) tick();
    chk("mid_rst_no_emit", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
